// File: rtl/fetch_sequencer.sv
// Program sequencer for the projetoProcessador core: walks start_addr..stop_addr on Din,
// pulses run per address, waits for a done rising edge. Optional watchdog: FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] stop_addr,
    input  logic              done,
    output logic [ADDR_W-1:0] Din,
    output logic              run,
    output logic              busy,
    output logic              finished,
    output logic [CNT_W-1:0]  exec_count,
    output logic              timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] stop_q, stop_nx, din_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic              finished_nx;
    logic              done_q;
    logic              completion;
    logic              expired;

    // A level of done left over from the previous instruction must not count.
    assign completion = (state == WAIT) && done && !done_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYC + 1);

    logic [WC_W-1:0] wait_cnt;
    logic            timeout_nx;

    assign expired = (state == WAIT) && !completion && (wait_cnt == WC_W'(TIMEOUT_CYC - 1));
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nx    = state;
        din_nx      = Din;
        stop_nx     = stop_q;
        cnt_nx      = exec_count;
        finished_nx = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        timeout_nx  = timeout;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ISSUE;
                    din_nx   = start_addr;
                    stop_nx  = stop_addr;
                    cnt_nx   = '0;
`ifdef FETCH_TIMEOUT_EN
                    timeout_nx = 1'b0;
`endif
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (completion) begin
                    if (exec_count != '1) cnt_nx = exec_count + CNT_W'(1);
                    if (Din == stop_q) begin
                        finished_nx = 1'b1;
                        state_nx    = IDLE;
                    end else begin
                        din_nx   = Din + ADDR_W'(1);
                        state_nx = ISSUE;
                    end
                end else if (expired) begin
`ifdef FETCH_TIMEOUT_EN
                    timeout_nx = 1'b1;
`endif
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // run/busy are derived from the next state so they line up with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            Din        <= '0;
            stop_q     <= '0;
            exec_count <= '0;
            run        <= 1'b0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of its peers.
            state      <= state_nx;
            Din        <= din_nx;
            stop_q     <= stop_nx;
            exec_count <= cnt_nx;
            run        <= (state_nx == ISSUE);
            busy       <= (state_nx != IDLE);
            finished   <= finished_nx;
            done_q     <= done;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= timeout_nx;
            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + WC_W'(1);
        end
    end
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Upstream stage for the `projetoProcessador` core. It walks a range of instruction-ROM addresses and presents each one on the core's `Din` input, then pulses `run`. It waits for the core's `done` before advancing, and counts completed instructions. It replaces hand-driven `Din`/`run` stimulus with a self-running program sequencer.

## Interface
- `ADDR_W`, 5, width of ROM address (`Din`)
- `CNT_W`, 8, width of `exec_count`
- `TIMEOUT_CYC`, 16, cycles allowed in WAIT before timeout (used only with `FETCH_TIMEOUT_EN`)

- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  begin a program run; sampled only in IDLE
- `start_addr`  in  ADDR_W  first ROM address to execute
- `stop_addr`  in  ADDR_W  last ROM address to execute (inclusive)
- `done`  in  1  core's instruction-complete flag
- `Din`  out  ADDR_W  ROM address driven to core
- `run`  out  1  one-cycle instruction launch to core
- `busy`  out  1  high in ISSUE and WAIT
- `finished`  out  1  one-cycle pulse after `stop_addr` instruction completes
- `exec_count`  out  CNT_W  instructions completed in current/last run
- `timeout`  out  1  sticky watchdog flag; constant 0 without `FETCH_TIMEOUT_EN`

## Operation
- States: IDLE, ISSUE, WAIT. All outputs are registered.
- Reset values: state=IDLE, `Din`=0, `run`=0, `busy`=0, `finished`=0, `exec_count`=0, `timeout`=0.
- IDLE:
  - `start`=1 → `Din`<=`start_addr`, `exec_count`<=0, `timeout`<=0, go to ISSUE.
  - `start_addr`/`stop_addr` are captured at that edge; later changes are ignored until the next start.
- ISSUE: `run`=1 for exactly this one cycle. Always go to WAIT.
- WAIT:
  - `run`=0. Completion is detected on a rising edge of `done` (`done`=1 and the previous-cycle `done`=0); the previous-`done` register resets to 0.
  - On completion, `exec_count` += 1, saturating at 2^CNT_W−1.
  - If `Din` equals captured `stop_addr` → `finished`<=1 for one cycle, go to IDLE; `Din` holds its last value.
  - Else `Din`<=`Din`+1 modulo 2^ADDR_W (31→0 wraps), go to ISSUE.
- A `done` high level carried over from the previous instruction is not a completion; a rising edge is required.
- `start` while busy is ignored.
- `start_addr`==`stop_addr` → exactly one instruction.
- `stop_addr` < `start_addr` → the range wraps through 0. Total instructions = ((stop−start) mod 2^ADDR_W) + 1.
- `reset` mid-run → outputs return to reset values asynchronously. No `finished` pulse.

## Timing
- `start` sampled at edge k → cycle k..k+1: `run`=1, `Din`=`start_addr`, `busy`=1.
- Edge k+1 → WAIT, `run`=0.
- `done` rising sampled at edge m:
  - Next instruction: `run`=1 with incremented `Din` in cycle m..m+1. This gives a 1-cycle turnaround.
  - Last instruction: `finished`=1, `busy`=0 in cycle m..m+1.
- `done` is never sampled during ISSUE; a rise occurring only in ISSUE is missed.
- `Din` is stable during the whole ISSUE+WAIT window of an instruction.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A wait counter clears on entry to WAIT.
  - When the counter reaches `TIMEOUT_CYC` without completion → `timeout`<=1 (sticky), state → IDLE, `busy`=0, no `finished` pulse.
  - `exec_count` keeps the completions counted so far.
  - `timeout` clears only on reset or the next accepted `start`.
- Not defined: no counter is generated, `timeout` is tied 0, and WAIT is held indefinitely.

## Test plan
- Reset asserted mid-WAIT (`Din`=3) → `Din`=0, `run`=0, `busy`=0, `exec_count`=0 immediately, before the next clock edge.
- `start_addr`=0, `stop_addr`=3, core model raises `done` 4 cycles after each `run` → `run` pulses at `Din`=0,1,2,3; `finished` one cycle; `exec_count`=4.
- `start_addr`=30, `stop_addr`=1 → `Din` sequence 30,31,0,1; `exec_count`=4.
- `done` held high across the ISSUE→WAIT boundary, then low 2 cycles, then high → exactly one completion counted; `start` pulsed while busy has no effect.
- `start_addr`=`stop_addr`=5 → single `run`, `finished` on the cycle after the `done` rise, `exec_count`=1.
- With `FETCH_TIMEOUT_EN`, `TIMEOUT_CYC`=16, `done` never rises → `timeout`=1 after 16 WAIT cycles, `busy`=0, no `finished`; next `start` clears `timeout`.
